// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: FIFO of retired register writes, drained as byte-serial frames.
// Optional WB_TRACE_SEQ_EN prepends an 8-bit sequence number to every frame.
module wb_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     wb_we,
  input  logic [4:0]               wb_addr,
  input  logic [31:0]              wb_data,
  input  logic [4:0]               wb_pc,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DROP_W-1:0]        drop_count,
  output logic                     overflow,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef WB_TRACE_SEQ_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif
  localparam int FW = NB * 8;
  localparam int EW = FW - 6;

  typedef enum logic {IDLE, SEND} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                ovf_q, ovf_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          dout_q, dout_d;
  logic [EW-1:0]       mem [DEPTH];
  logic [EW-1:0]       head, entry;
  logic [FW-1:0]       head_frame;
  logic                push, fire, last, pop, full, accept, drop;

`ifdef WB_TRACE_SEQ_EN
  logic [7:0] seq_q, seq_d;
  assign entry      = {seq_q, wb_pc, wb_addr, wb_data};
  assign head_frame = {head[49:42], 3'b0, head[41:37], 3'b0, head[36:32], head[31:0]};
`else
  assign entry      = {wb_pc, wb_addr, wb_data};
  assign head_frame = {3'b0, head[41:37], 3'b0, head[36:32], head[31:0]};
`endif

  assign head   = mem[rptr_q[AW-1:0]];
  assign push   = wb_we && (wb_addr != 5'd0) && !clr;
  assign fire   = (state_q == SEND) && out_ready;
  assign last   = (idx_q == 3'(NB-1));
  // A pop while full frees the slot the same-cycle push lands in.
  assign pop    = (count_q != '0) && ((state_q == IDLE) || (fire && last));
  assign full   = (count_q == CW'(DEPTH));
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
`ifdef WB_TRACE_SEQ_EN
    seq_d   = seq_q;
    if (accept) seq_d = seq_q + 8'd1;
`endif
    if (accept) wptr_d = wptr_q + CW'(1);
    if (pop)    rptr_d = rptr_q + CW'(1);
    count_d = count_q + CW'(accept) - CW'(pop);
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
    end
    if (pop) begin
      state_d = SEND;
      frame_d = head_frame;
      idx_d   = 3'd0;
      dout_d  = head_frame[FW-1 -: 8];
    end else if (fire) begin
      if (last) begin
        state_d = IDLE;
      end else begin
        frame_d = frame_q << 8;
        idx_d   = idx_q + 3'd1;
        dout_d  = frame_d[FW-1 -: 8];
      end
    end
    if (clr) begin
      state_d = IDLE;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      drop_d  = '0;
      ovf_d   = 1'b0;
      idx_d   = 3'd0;
      dout_d  = 8'h00;
`ifdef WB_TRACE_SEQ_EN
      seq_d   = 8'h00;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wptr_q[AW-1:0]] <= entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      frame_q <= '0;
      idx_q   <= 3'd0;
      dout_q  <= 8'h00;
`ifdef WB_TRACE_SEQ_EN
      seq_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
`ifdef WB_TRACE_SEQ_EN
      seq_q   <= seq_d;
`endif
    end
  end

  assign out_data   = dout_q;
  assign out_valid  = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign count      = count_q;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;
endmodule
